rr_arb_mux: RTL and testbench

- Parametrised M-to-1 selector with valid/ready handshakes, round-robin or fixed-priority arbitration, and a registered output stage.
- Merges requesters that share one downstream consumer. Example: instruction-fetch and load/store requests into a single memory port.
- Replaces fixed 4-way combinational selection wherever the select must be arbitrated and held across backpressure.

---
 rtl/rr_arb_mux_pkg.sv | 25 ++
 rtl/rr_arb_mux_if.sv | 52 +++++
 rtl/rr_arb_mux_grant.sv | 65 ++++++
 rtl/rr_arb_mux.sv | 95 +++++++++
 tb/tb_rr_arb_mux.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/rr_arb_mux_pkg.sv
// -----------------------------------------------------------------------------
// rr_arb_mux_pkg
// Shared definitions for the rr_arb_mux arbitrated selector:
//   - ARB_FIXED / ARB_RR : arbitration-mode encodings for the RR parameter
//   - clog2()            : constant function used to size grant indices
// No ports (package).
// -----------------------------------------------------------------------------
package rr_arb_mux_pkg;

   localparam int ARB_FIXED = 32'sd0;
   localparam int ARB_RR    = 32'sd1;

   // Ceiling log2 for elaboration-time sizing; returns 1 for value 2.
   function automatic int clog2(input int unsigned value);
      int result;
      result = 32'sd0;
      for (int i = 0; i < 32; i++) begin
         if ((32'd1 << i) < value) begin
            result = i + 32'sd1;
         end
      end
      return result;
   endfunction

endpackage : rr_arb_mux_pkg

// File: rtl/rr_arb_mux_if.sv
// -----------------------------------------------------------------------------
// rr_arb_mux_if
// Bundles the request side (M valid/ready/data channels) and the single
// downstream output of rr_arb_mux.
//   slave  : view taken by rr_arb_mux (accepts requests, drives the output)
//   master : view taken by the environment (drives requests, consumes output)
// Signals:
//   in_valid [M]      per-channel request valid
//   in_data  [M*N]    channel i at bits [i*N +: N]
//   in_ready [M]      per-channel accept, at most one bit set
//   out_valid         output register holds a beat
//   out_data [N]      registered data of the granted beat
//   out_sel  [SEL_W]  channel that supplied out_data
//   out_ready         downstream accept
// -----------------------------------------------------------------------------
interface rr_arb_mux_if #(
   parameter int N = 32,
   parameter int M = 4
);
   import rr_arb_mux_pkg::*;

   localparam int SEL_W = clog2(M);

   logic [M-1:0]     in_valid;
   logic [M*N-1:0]   in_data;
   logic [M-1:0]     in_ready;
   logic             out_valid;
   logic [N-1:0]     out_data;
   logic [SEL_W-1:0] out_sel;
   logic             out_ready;

   modport slave (
      input  in_valid,
      input  in_data,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_data,
      output out_sel
   );

   modport master (
      output in_valid,
      output in_data,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_data,
      input  out_sel
   );

endinterface : rr_arb_mux_if

// File: rtl/rr_arb_mux_grant.sv
// -----------------------------------------------------------------------------
// rr_grant
// Combinational grant selection for rr_arb_mux.
//   RR = ARB_RR    : first valid channel scanning upward from i_last_grant+1
//                    with wrap-around.
//   RR = ARB_FIXED : lowest-index valid channel.
// Ports:
//   i_valid      [M]      request valids
//   i_last_grant [SEL_W]  most recently granted channel (ignored when fixed)
//   o_grant      [M]      one-hot grant, all-zero when nothing is valid
//   o_idx        [SEL_W]  index of the granted channel (0 when no grant)
// -----------------------------------------------------------------------------
module rr_grant
   import rr_arb_mux_pkg::*;
#(
   parameter  int M     = 4,
   parameter  int RR    = ARB_RR,
   localparam int SEL_W = clog2(M)
) (
   input  logic [M-1:0]     i_valid,
   input  logic [SEL_W-1:0] i_last_grant,
   output logic [M-1:0]     o_grant,
   output logic [SEL_W-1:0] o_idx
);

   int w_best;
   int w_dist;

   // Rank every channel by its distance from the start of the scan and keep
   // the closest valid one; the start is last_grant+1 in round-robin mode
   // and channel 0 in fixed mode.
   always_comb begin
      o_grant = '0;
      o_idx   = '0;
      w_best  = M;
      w_dist  = 32'sd0;
      for (int j = 0; j < M; j++) begin
         if (RR == ARB_RR) begin
            w_dist = j - (int'(i_last_grant) + 32'sd1);
            if (w_dist < 32'sd0) begin
               w_dist = w_dist + M;
            end else begin
               w_dist = w_dist;
            end
         end else begin
            w_dist = j;
         end
         if (i_valid[j] && (w_dist < w_best)) begin
            w_best = w_dist;
            o_idx  = SEL_W'(j);
         end else begin
            w_best = w_best;
         end
      end
      // w_best stays at M only when no channel is valid.
      for (int j = 0; j < M; j++) begin
         if ((w_best < M) && (o_idx == SEL_W'(j))) begin
            o_grant[j] = 1'b1;
         end else begin
            o_grant[j] = 1'b0;
         end
      end
   end

endmodule : rr_grant

// File: rtl/rr_arb_mux.sv
// -----------------------------------------------------------------------------
// rr_arb_mux
// M-to-1 arbitrated selector with valid/ready handshakes and a registered
// output stage. One beat per cycle while the consumer accepts; the output
// register refills in the same cycle it drains.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-low reset (0 = reset)
//   bus  : rr_arb_mux_if.slave (request channels in, single output out)
// Parameters:
//   N  data width, M channel count (2..16), RR arbitration mode.
// -----------------------------------------------------------------------------
module rr_arb_mux
   import rr_arb_mux_pkg::*;
#(
   parameter  int N     = 32,
   parameter  int M     = 4,
   parameter  int RR    = ARB_RR,
   localparam int SEL_W = clog2(M)
) (
   input  logic          clk,
   input  logic          rst,
   rr_arb_mux_if.slave   bus
);

   logic             r_out_valid;
   logic [N-1:0]     r_out_data;
   logic [SEL_W-1:0] r_out_sel;
   logic [SEL_W-1:0] r_last_grant;

   logic             w_load_en;
   logic             w_take;
   logic [M-1:0]     w_grant;
   logic [SEL_W-1:0] w_idx;
   logic [N-1:0]     w_sel_data;

   // The register can accept a beat when empty or draining this cycle;
   // rst gates it so nothing is accepted (and lost) during reset.
   assign w_load_en = rst & (~r_out_valid | bus.out_ready);
   assign w_take    = w_load_en & (|w_grant);

   rr_grant #(
      .M  (M),
      .RR (RR)
   ) u_grant (
      .i_valid      (bus.in_valid),
      .i_last_grant (r_last_grant),
      .o_grant      (w_grant),
      .o_idx        (w_idx)
   );

   // AND-OR select of the granted channel's data using the one-hot grant.
   always_comb begin
      w_sel_data = '0;
      for (int j = 0; j < M; j++) begin
         if (w_grant[j]) begin
            w_sel_data = w_sel_data | bus.in_data[j*N +: N];
         end else begin
            w_sel_data = w_sel_data;
         end
      end
   end

   // Output register and round-robin pointer.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_out_valid  <= 1'b0;
         r_out_data   <= '0;
         r_out_sel    <= '0;
         r_last_grant <= SEL_W'(M - 1);
      end else begin
         if (w_take) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_sel_data;
            r_out_sel   <= w_idx;
         end else if (r_out_valid && bus.out_ready) begin
            // Drain without refill: data and select keep their last values.
            r_out_valid <= 1'b0;
         end else begin
            r_out_valid <= r_out_valid;
         end
         if ((RR == ARB_RR) && w_take) begin
            r_last_grant <= w_idx;
         end else begin
            r_last_grant <= r_last_grant;
         end
      end
   end

   assign bus.in_ready  = w_grant & {M{w_load_en}};
   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_out_data;
   assign bus.out_sel   = r_out_sel;

endmodule : rr_arb_mux

// File: tb/tb_rr_arb_mux.sv
// -----------------------------------------------------------------------------
// tb_rr_arb_mux
// Three instances share clk/rst: (M=4,RR=1), (M=4,RR=0), (M=3,RR=1).
// A behavioural model (queue-free scan over channel indices) predicts every
// cycle's in_ready and registered outputs; directed literal expectations pin
// the model for the key scenarios, then randomized traffic runs.
// -----------------------------------------------------------------------------
module tb_rr_arb_mux;
   import rr_arb_mux_pkg::*;

   localparam int NI = 3;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [3:0]  s_valid  [NI];
   logic [31:0] s_data   [NI][4];
   logic        s_oready [NI];

   logic [3:0]  w_rdy [NI];
   logic        w_ov  [NI];
   logic [31:0] w_od  [NI];
   logic [1:0]  w_os  [NI];

   // model state (m_) and the state predicted for after the next edge (n_)
   bit          m_known [NI];
   bit          m_ov    [NI];
   logic [31:0] m_od    [NI];
   int          m_os    [NI];
   int          m_lg    [NI];
   bit          n_known [NI];
   bit          n_ov    [NI];
   logic [31:0] n_od    [NI];
   int          n_os    [NI];
   int          n_lg    [NI];

   int n_checks = 0;
   int n_errors = 0;

   rr_arb_mux_if #(.N(32), .M(4)) u_if0 ();
   rr_arb_mux_if #(.N(32), .M(4)) u_if1 ();
   rr_arb_mux_if #(.N(32), .M(3)) u_if2 ();

   assign u_if0.in_valid  = s_valid[0];
   assign u_if0.in_data   = {s_data[0][3], s_data[0][2], s_data[0][1], s_data[0][0]};
   assign u_if0.out_ready = s_oready[0];
   assign u_if1.in_valid  = s_valid[1];
   assign u_if1.in_data   = {s_data[1][3], s_data[1][2], s_data[1][1], s_data[1][0]};
   assign u_if1.out_ready = s_oready[1];
   assign u_if2.in_valid  = s_valid[2][2:0];
   assign u_if2.in_data   = {s_data[2][2], s_data[2][1], s_data[2][0]};
   assign u_if2.out_ready = s_oready[2];

   assign w_rdy[0] = u_if0.in_ready;
   assign w_rdy[1] = u_if1.in_ready;
   assign w_rdy[2] = {1'b0, u_if2.in_ready};
   assign w_ov[0]  = u_if0.out_valid;
   assign w_ov[1]  = u_if1.out_valid;
   assign w_ov[2]  = u_if2.out_valid;
   assign w_od[0]  = u_if0.out_data;
   assign w_od[1]  = u_if1.out_data;
   assign w_od[2]  = u_if2.out_data;
   assign w_os[0]  = u_if0.out_sel;
   assign w_os[1]  = u_if1.out_sel;
   assign w_os[2]  = u_if2.out_sel;

   rr_arb_mux #(.N(32), .M(4), .RR(ARB_RR))    u_dut0 (.clk(clk), .rst(rst), .bus(u_if0.slave));
   rr_arb_mux #(.N(32), .M(4), .RR(ARB_FIXED)) u_dut1 (.clk(clk), .rst(rst), .bus(u_if1.slave));
   rr_arb_mux #(.N(32), .M(3), .RR(ARB_RR))    u_dut2 (.clk(clk), .rst(rst), .bus(u_if2.slave));

   function automatic int m_of(input int k);
      return (k == 2) ? 3 : 4;
   endfunction

   function automatic bit rr_of(input int k);
      return (k != 1);
   endfunction

   task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s inst%0d: got %h expected %h at %0t", name, k, act, exp, $time);
      end
   endtask

   // Which channel the rules pick: scan order starts after the last grant
   // (round-robin) or at channel 0 (fixed); -1 when nothing is valid.
   function automatic int model_grant(input int k);
      int m;
      int c;
      m = m_of(k);
      for (int i = 0; i < m; i++) begin
         c = rr_of(k) ? ((m_lg[k] + 1 + i) % m) : i;
         if (s_valid[k][c[1:0]]) return c;
      end
      return -1;
   endfunction

   // Compare every instance against the model, then predict the next state.
   task automatic compare_all();
      int g;
      bit le;
      logic [3:0] exp_rdy;
      for (int k = 0; k < NI; k++) begin
         g  = model_grant(k);
         le = rst && (!m_ov[k] || s_oready[k]);
         exp_rdy = 4'b0000;
         if (le && (g >= 0)) exp_rdy[g[1:0]] = 1'b1;
         if (m_known[k] || !rst) chk("in_ready", k, 32'(w_rdy[k]), 32'(exp_rdy));
         if (m_known[k]) begin
            chk("out_valid", k, 32'(w_ov[k]), 32'(m_ov[k]));
            chk("out_data", k, w_od[k], m_od[k]);
            chk("out_sel", k, 32'(w_os[k]), 32'(m_os[k]));
         end
         n_known[k] = m_known[k];
         n_ov[k] = m_ov[k];
         n_od[k] = m_od[k];
         n_os[k] = m_os[k];
         n_lg[k] = m_lg[k];
         if (!rst) begin
            n_known[k] = 1'b1;
            n_ov[k] = 1'b0;
            n_od[k] = 32'h0;
            n_os[k] = 0;
            n_lg[k] = m_of(k) - 1;
         end else if (le && (g >= 0)) begin
            n_ov[k] = 1'b1;
            n_od[k] = s_data[k][g[1:0]];
            n_os[k] = g;
            if (rr_of(k)) n_lg[k] = g;
         end else if (m_ov[k] && s_oready[k]) begin
            n_ov[k] = 1'b0;
         end
      end
   endtask

   // One clock: check at the falling edge, then advance the model just past
   // the rising edge so callers may drive new inputs and read outputs.
   task automatic step();
      @(negedge clk);
      compare_all();
      @(posedge clk);
      #1;
      for (int k = 0; k < NI; k++) begin
         m_known[k] = n_known[k];
         m_ov[k] = n_ov[k];
         m_od[k] = n_od[k];
         m_os[k] = n_os[k];
         m_lg[k] = n_lg[k];
      end
   endtask

   task automatic drive_all(input logic [3:0] v, input logic ordy);
      for (int k = 0; k < NI; k++) begin
         s_valid[k]  = v;
         s_oready[k] = ordy;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

   initial begin
      rst = 1'b0;
      for (int k = 0; k < NI; k++) begin
         m_known[k] = 1'b0;
         m_ov[k] = 1'b0;
         m_od[k] = 32'h0;
         m_os[k] = 0;
         m_lg[k] = 0;
         for (int i = 0; i < 4; i++) s_data[k][i] = 32'(32'hA0 + i);
      end
      drive_all(4'b1111, 1'b1);

      // reset held two edges with everything valid
      step();
      step();
      for (int k = 0; k < NI; k++) begin
         chk("rst_ready_lit", k, 32'(w_rdy[k]), 32'h0);
         chk("rst_valid_lit", k, 32'(w_ov[k]), 32'h0);
         chk("rst_data_lit", k, w_od[k], 32'h0);
         chk("rst_sel_lit", k, 32'(w_os[k]), 32'h0);
      end

      // release: round-robin sequence with all channels valid
      rst = 1'b1;
      #1;
      chk("first_grant_lit", 0, 32'(w_rdy[0]), 32'h1);
      for (int i = 0; i < 6; i++) begin
         step();
         chk("rr4_seq_lit", 0, 32'(w_os[0]), 32'(i % 4));
         chk("rr4_data_lit", 0, w_od[0], 32'(32'hA0 + (i % 4)));
         chk("rr3_seq_lit", 2, 32'(w_os[2]), 32'(i % 3));
         chk("fixed_all_lit", 1, 32'(w_os[1]), 32'h0);
      end

      // reset while a beat is pending: discarded, then restart at channel 0
      rst = 1'b0;
      step();
      chk("midrst_valid_lit", 2, 32'(w_ov[2]), 32'h0);
      rst = 1'b1;
      step();
      chk("midrst_restart_lit", 2, 32'(w_os[2]), 32'h0);
      chk("midrst_restart_v_lit", 2, 32'(w_ov[2]), 32'h1);

      // fixed priority with channels 1 and 3 requesting
      drive_all(4'b1010, 1'b1);
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("fixed_no_rdy3_lit", 1, 32'(w_rdy[1][3]), 32'h0);
         step();
         chk("fixed_sel1_lit", 1, 32'(w_os[1]), 32'h1);
      end
      drive_all(4'b1000, 1'b1);
      step();
      chk("fixed_sel3_lit", 1, 32'(w_os[1]), 32'h3);

      // backpressure: park DEADBEEF from channel 2, stall for five cycles
      rst = 1'b0;
      step();
      rst = 1'b1;
      for (int k = 0; k < NI; k++) s_data[k][2] = 32'hDEAD_BEEF;
      drive_all(4'b0100, 1'b1);
      step();
      chk("bp_load_sel_lit", 0, 32'(w_os[0]), 32'h2);
      chk("bp_load_data_lit", 0, w_od[0], 32'hDEAD_BEEF);
      drive_all(4'b1111, 1'b0);
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("bp_ready_lit", 0, 32'(w_rdy[0]), 32'h0);
         step();
         chk("bp_valid_lit", 0, 32'(w_ov[0]), 32'h1);
         chk("bp_sel_lit", 0, 32'(w_os[0]), 32'h2);
         chk("bp_data_lit", 0, w_od[0], 32'hDEAD_BEEF);
      end
      drive_all(4'b1111, 1'b1);
      #1;
      chk("bp_release_rdy_lit", 0, 32'(w_rdy[0]), 32'h8);
      step();
      chk("bp_next_sel_lit", 0, 32'(w_os[0]), 32'h3);

      // drain and refill in the same cycle, then drain to empty
      drive_all(4'b0001, 1'b1);
      #1;
      chk("refill_rdy_lit", 0, 32'(w_rdy[0]), 32'h1);
      step();
      chk("refill_valid_lit", 0, 32'(w_ov[0]), 32'h1);
      chk("refill_data_lit", 0, w_od[0], 32'hA0);
      drive_all(4'b0000, 1'b1);
      step();
      chk("drain_valid_lit", 0, 32'(w_ov[0]), 32'h0);
      chk("drain_hold_data_lit", 0, w_od[0], 32'hA0);

      // randomized traffic, backpressure and occasional reset
      for (int c = 0; c < 3000; c++) begin
         rst = ($urandom_range(0, 99) != 0);
         for (int k = 0; k < NI; k++) begin
            s_valid[k]  = 4'($urandom_range(0, 15));
            s_oready[k] = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 4; i++) s_data[k][i] = $urandom;
         end
         step();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule : tb_rr_arb_mux
